// File: rtl/hex_text_writer.sv
// hex_text_writer: turns hex-render and screen-clear requests into single-cycle
// character display RAM writes. Rev 1.0
`default_nettype none

module hex_text_writer #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] BLANK_CHAR     = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_row,
  input  logic [5:0]  req_col,
  input  logic [15:0] req_value,
  input  logic [1:0]  req_ndig,
  input  logic        clr_req,
  output logic        busy,
  output logic [9:0]  ram_Adr,
  output logic [7:0]  ram_Data,
  output logic        write_Ram
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEX   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic [3:0]  r_row, w_row;
  logic [5:0]  r_col, w_col;
  logic [15:0] r_value, w_value;
  logic [1:0]  r_ndig, w_ndig;
  logic [2:0]  r_idx, w_idx;
  logic [10:0] r_cnt, w_cnt;
  logic        r_ready, w_ready;
  logic        r_wr, w_wr;
  logic [9:0]  r_adr, w_adr;
  logic [7:0]  r_data, w_data;

  function automatic logic [7:0] f_hex_char(input logic [15:0] v, input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Digit 0 is emitted on the accept edge itself so bursts are separated by one idle cycle.
  always_comb begin
    w_state = r_state;
    w_row   = r_row;
    w_col   = r_col;
    w_value = r_value;
    w_ndig  = r_ndig;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_wr    = 1'b0;
    w_adr   = r_adr;
    w_data  = r_data;
    case (r_state)
      S_IDLE: begin
        if (r_ready) begin
          if (clr_req) begin
            w_state = S_CLEAR;
            w_cnt   = 11'd0;
          end else if (req_valid) begin
            w_state = S_HEX;
            w_row   = req_row;
            w_col   = req_col;
            w_value = req_value;
            w_ndig  = req_ndig;
            w_idx   = 3'd1;
            w_wr    = 1'b1;
            w_adr   = {req_row, req_col};
            w_data  = f_hex_char(req_value, req_ndig);
          end
        end
      end
      S_HEX: begin
        if (r_idx > {1'b0, r_ndig}) begin
          w_state = S_IDLE;
        end else begin
          w_wr   = 1'b1;
          w_adr  = {r_row, r_col + {4'h0, r_idx[1:0]}};
          w_data = f_hex_char(r_value, r_ndig - r_idx[1:0]);
          w_idx  = r_idx + 3'd1;
        end
      end
      S_CLEAR: begin
        // The extra counter bit marks completion so the address never wraps.
        if (r_cnt[10]) begin
          w_state = S_IDLE;
        end else begin
          w_wr   = 1'b1;
          w_adr  = r_cnt[9:0];
          w_data = BLANK_CHAR;
          w_cnt  = r_cnt + 11'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) r_state <= S_CLEAR;
      else                r_state <= S_IDLE;
      r_row   <= 4'h0;
      r_col   <= 6'h0;
      r_value <= 16'h0;
      r_ndig  <= 2'd0;
      r_idx   <= 3'd0;
      r_cnt   <= 11'd0;
      r_ready <= 1'b0;
      r_wr    <= 1'b0;
      r_adr   <= 10'h0;
      r_data  <= 8'h0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_value <= w_value;
      r_ndig  <= w_ndig;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_ready <= w_ready;
      r_wr    <= w_wr;
      r_adr   <= w_adr;
      r_data  <= w_data;
    end
  end

  assign req_ready = r_ready;
  assign busy      = ~r_ready;
  assign write_Ram = r_wr;
  assign ram_Adr   = r_adr;
  assign ram_Data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_hex_text_writer.sv
// tb_hex_text_writer: directed self-checking bench for hex_text_writer.
`default_nettype none

module tb_hex_text_writer;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic        req_valid, req_valid_b, clr_req, clr_req_b;
  logic [3:0]  req_row;
  logic [5:0]  req_col;
  logic [15:0] req_value;
  logic [1:0]  req_ndig;
  logic        ready_a, busy_a, wr_a, ready_b, busy_b, wr_b;
  logic [9:0]  adr_a, adr_b;
  logic [7:0]  data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_text_writer #(.CLEAR_ON_RESET(1'b1), .BLANK_CHAR(8'h20)) u_dut_a (
    .clk(clk), .reset_n(rst_n_a), .req_valid(req_valid), .req_ready(ready_a),
    .req_row(req_row), .req_col(req_col), .req_value(req_value), .req_ndig(req_ndig),
    .clr_req(clr_req), .busy(busy_a), .ram_Adr(adr_a), .ram_Data(data_a), .write_Ram(wr_a)
  );

  hex_text_writer #(.CLEAR_ON_RESET(1'b0), .BLANK_CHAR(8'h20)) u_dut_b (
    .clk(clk), .reset_n(rst_n_b), .req_valid(req_valid_b), .req_ready(ready_b),
    .req_row(req_row), .req_col(req_col), .req_value(req_value), .req_ndig(req_ndig),
    .clr_req(clr_req_b), .busy(busy_b), .ram_Adr(adr_b), .ram_Data(data_b), .write_Ram(wr_b)
  );

  task automatic test_reset();
    int pulses, bad, b_writes;
    logic rdy_after;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_a !== 1'b0)    begin n_fail++; $display("FAIL reset_wr got %b exp 0", wr_a); end
    n_checks++; if (adr_a !== 10'h0)  begin n_fail++; $display("FAIL reset_adr got %h exp 000", adr_a); end
    n_checks++; if (data_a !== 8'h0)  begin n_fail++; $display("FAIL reset_data got %h exp 00", data_a); end
    n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a got %b exp 0", ready_a); end
    n_checks++; if (busy_a !== 1'b1)  begin n_fail++; $display("FAIL reset_busy_a got %b exp 1", busy_a); end
    n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b got %b exp 0", ready_b); end
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    pulses = 0; bad = 0; b_writes = 0; rdy_after = 1'b0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      if (wr_b) b_writes++;
      if (wr_a) begin
        if (adr_a !== pulses[9:0] || data_a !== 8'h20 || ready_a !== 1'b0) bad++;
        pulses++;
      end else if (pulses > 0) begin
        rdy_after = ready_a;
        break;
      end
    end
    n_checks++; if (pulses !== 1024)   begin n_fail++; $display("FAIL clear_pulses got %0d exp 1024", pulses); end
    n_checks++; if (bad !== 0)         begin n_fail++; $display("FAIL clear_content got %0d bad writes exp 0", bad); end
    n_checks++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL clear_ready_after got %b exp 1", rdy_after); end
    n_checks++; if (b_writes !== 0)    begin n_fail++; $display("FAIL noclear_writes got %0d exp 0", b_writes); end
    n_checks++; if (ready_b !== 1'b1)  begin n_fail++; $display("FAIL noclear_ready got %b exp 1", ready_b); end
  endtask

  task automatic test_hex_beef();
    logic [9:0] exp_adr [4] = '{10'h08A, 10'h08B, 10'h08C, 10'h08D};
    logic [7:0] exp_dat [4] = '{8'h42, 8'h45, 8'h45, 8'h46};
    req_row = 4'd2; req_col = 6'd10; req_value = 16'hBEEF; req_ndig = 2'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_value = 16'h0000; req_col = 6'd0; req_row = 4'd7;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_a !== 1'b1 || adr_a !== exp_adr[k] || data_a !== exp_dat[k] || ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL beef_digit%0d got wr=%b adr=%h data=%h rdy=%b exp wr=1 adr=%h data=%h rdy=0",
                 k, wr_a, adr_a, data_a, ready_a, exp_adr[k], exp_dat[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (wr_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL beef_end got wr=%b rdy=%b exp wr=0 rdy=1", wr_a, ready_a);
    end
  endtask

  task automatic test_hex_wrap();
    logic [9:0] exp_adr [2] = '{10'h3FF, 10'h3C0};
    logic [7:0] exp_dat [2] = '{8'h32, 8'h33};
    req_row = 4'd15; req_col = 6'd63; req_value = 16'h0123; req_ndig = 2'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (wr_a !== 1'b1 || adr_a !== exp_adr[k] || data_a !== exp_dat[k]) begin
        n_fail++;
        $display("FAIL wrap_digit%0d got wr=%b adr=%h data=%h exp wr=1 adr=%h data=%h",
                 k, wr_a, adr_a, data_a, exp_adr[k], exp_dat[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (wr_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL wrap_end got wr=%b rdy=%b exp wr=0 rdy=1", wr_a, ready_a);
    end
  endtask

  task automatic test_clear_priority();
    int nw, bad, last_blank, first_hex;
    logic [9:0] h_adr [2] = '{10'h0, 10'h0};
    logic [7:0] h_dat [2] = '{8'h0, 8'h0};
    nw = 0; bad = 0; last_blank = -100; first_hex = 0;
    req_row = 4'd1; req_col = 6'd0; req_value = 16'h00A5; req_ndig = 2'd1;
    req_valid = 1'b1; clr_req = 1'b1;
    for (int cyc = 0; cyc < 1300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) clr_req = 1'b0;
      if (wr_a) begin
        if (nw < 1024) begin
          if (adr_a !== nw[9:0] || data_a !== 8'h20) bad++;
          last_blank = cyc;
        end else begin
          if (nw == 1024) begin
            first_hex = cyc;
            req_valid = 1'b0;
          end
          h_adr[nw - 1024] = adr_a;
          h_dat[nw - 1024] = data_a;
        end
        nw++;
        if (nw == 1026) break;
      end
    end
    req_valid = 1'b0;
    n_checks++; if (nw !== 1026) begin n_fail++; $display("FAIL prio_writes got %0d exp 1026", nw); end
    n_checks++; if (bad !== 0)   begin n_fail++; $display("FAIL prio_clear_content got %0d bad exp 0", bad); end
    n_checks++;
    if (h_adr[0] !== 10'h040 || h_dat[0] !== 8'h41) begin
      n_fail++; $display("FAIL prio_hex0 got adr=%h data=%h exp adr=040 data=41", h_adr[0], h_dat[0]);
    end
    n_checks++;
    if (h_adr[1] !== 10'h041 || h_dat[1] !== 8'h35) begin
      n_fail++; $display("FAIL prio_hex1 got adr=%h data=%h exp adr=041 data=35", h_adr[1], h_dat[1]);
    end
    n_checks++;
    if (first_hex - last_blank !== 2) begin
      n_fail++; $display("FAIL prio_gap got %0d exp 2", first_hex - last_blank);
    end
    @(negedge clk);
    n_checks++;
    if (wr_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL prio_end got wr=%b rdy=%b exp wr=0 rdy=1", wr_a, ready_a);
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0] exp_adr [4] = '{10'h000, 10'h000, 10'h001, 10'h001};
    logic [7:0] exp_dat [4] = '{8'h35, 8'h35, 8'h41, 8'h41};
    req_row = 4'd0; req_col = 6'd0; req_value = 16'h0005; req_ndig = 2'd0; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin req_value = 16'h000A; req_col = 6'd1; end
      if (k == 2) req_valid = 1'b0;
      n_checks++;
      if (wr_a !== exp_wr[k] || (exp_wr[k] && (adr_a !== exp_adr[k] || data_a !== exp_dat[k]))) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got wr=%b adr=%h data=%h exp wr=%b adr=%h data=%h",
                 k, wr_a, adr_a, data_a, exp_wr[k], exp_adr[k], exp_dat[k]);
      end
    end
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", ready_a); end
  endtask

  task automatic test_reset_abort();
    int post_writes;
    req_row = 4'd3; req_col = 6'd5; req_value = 16'h1234; req_ndig = 2'd3; req_valid_b = 1'b1;
    @(negedge clk);
    req_valid_b = 1'b0;
    n_checks++;
    if (wr_b !== 1'b1 || adr_b !== 10'h0C5 || data_b !== 8'h31) begin
      n_fail++; $display("FAIL abort_first got wr=%b adr=%h data=%h exp wr=1 adr=0C5 data=31", wr_b, adr_b, data_b);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (wr_b !== 1'b1 || adr_b !== 10'h0C6 || data_b !== 8'h32) begin
      n_fail++; $display("FAIL abort_second got wr=%b adr=%h data=%h exp wr=1 adr=0C6 data=32", wr_b, adr_b, data_b);
    end
    rst_n_b = 1'b0;
    #1;
    n_checks++; if (wr_b !== 1'b0)    begin n_fail++; $display("FAIL abort_wr_drop got %b exp 0", wr_b); end
    n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset got %b exp 0", ready_b); end
    @(negedge clk);
    @(negedge clk);
    rst_n_b = 1'b1;
    post_writes = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_b) post_writes++;
    end
    n_checks++; if (post_writes !== 0) begin n_fail++; $display("FAIL abort_post_writes got %0d exp 0", post_writes); end
    n_checks++; if (ready_b !== 1'b1)  begin n_fail++; $display("FAIL abort_ready_after got %b exp 1", ready_b); end
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_valid = 1'b0; req_valid_b = 1'b0; clr_req = 1'b0; clr_req_b = 1'b0;
    req_row = 4'd0; req_col = 6'd0; req_value = 16'h0; req_ndig = 2'd0;
    test_reset();
    test_hex_beef();
    test_hex_wrap();
    test_clear_priority();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
